// File: rtl/jtag_dtm_oversampled_if.sv
// jtag_dtm_oversampled_if: DMI request/response channel between the DTM (master) and the debug module (slave).
interface jtag_dtm_oversampled_if #(parameter int ABITS = 7);
    logic             dmi_req_valid;
    logic             dmi_req_ready;
    logic [ABITS-1:0] dmi_req_addr;
    logic [1:0]       dmi_req_op;
    logic [31:0]      dmi_req_data;
    logic             dmi_resp_valid;
    logic             dmi_resp_ready;
    logic [31:0]      dmi_resp_data;
    logic [1:0]       dmi_resp_resp;
    modport master (
        output dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, dmi_resp_ready,
        input  dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_resp
    );
    modport slave (
        input  dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data, dmi_resp_ready,
        output dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_resp
    );
endinterface

// File: rtl/jtag_dtm_oversampled.sv
// jtag_dtm_oversampled: JTAG TAP + RISC-V DTM with pins oversampled in the clk domain.
module jtag_dtm_oversampled #(
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001,
    parameter int          ABITS        = 7,
    parameter logic [2:0]  IDLE_HINT    = 3'd1
) (
    input  logic clk,
    input  logic rst,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    input  logic trst_n,
    output logic tdo,
    output logic tdo_oe,
    jtag_dtm_oversampled_if.master dmi
);
    localparam int DW = ABITS + 34;
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
        UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;
    typedef enum logic [1:0] {D_IDLE, D_REQ, D_RESP} dmi_e;

    logic [3:0]       s0_q, s1_q;
    logic             tck_p_q;
    logic             trst_s, tck_s, tms_s, tdi_s, rise, fall;
    tap_e             tap_q, tap_d;
    dmi_e             dmi_q, dmi_d;
    logic [4:0]       ir_sr_q, ir_sr_d, ir_q, ir_d;
    logic [DW-1:0]    dr_q, dr_d;
    logic             tdo_q, tdo_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d, rdata_q, rdata_d, dtmcs;
    logic [1:0]       op_q, op_d, resp_q, resp_d, stat_q, stat_d, cap_st;
    logic             sel_id, sel_cs, sel_dmi, sel_byp;
    logic             cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr, hard;

    assign {trst_s, tck_s, tms_s, tdi_s} = s1_q;
    assign rise    = tck_s & ~tck_p_q;
    assign fall    = ~tck_s & tck_p_q;
    assign sel_id  = ir_q == 5'h01;
    assign sel_cs  = ir_q == 5'h10;
    assign sel_dmi = ir_q == 5'h11;
    assign sel_byp = !(sel_id || sel_cs || sel_dmi);
    assign cap_ir  = rise && tap_q == CAP_IR;
    assign sh_ir   = rise && tap_q == SH_IR;
    assign upd_ir  = rise && tap_q == UPD_IR;
    assign cap_dr  = rise && tap_q == CAP_DR;
    assign sh_dr   = rise && tap_q == SH_DR;
    assign upd_dr  = rise && tap_q == UPD_DR;
    assign hard    = upd_dr && sel_cs && dr_q[17];
    assign dtmcs   = {17'b0, IDLE_HINT, stat_q, 6'(ABITS), 4'd1};
    assign cap_st  = (dmi_q != D_IDLE || stat_q == 2'd3) ? 2'd3 : resp_q;

    always_comb begin
        tap_d = tap_q;
        if (rise)
            case (tap_q)
                TLR:     tap_d = tms_s ? TLR    : RTI;
                RTI:     tap_d = tms_s ? SEL_DR : RTI;
                SEL_DR:  tap_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:  tap_d = tms_s ? EX1_DR : SH_DR;
                SH_DR:   tap_d = tms_s ? EX1_DR : SH_DR;
                EX1_DR:  tap_d = tms_s ? UPD_DR : PAU_DR;
                PAU_DR:  tap_d = tms_s ? EX2_DR : PAU_DR;
                EX2_DR:  tap_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR:  tap_d = tms_s ? SEL_DR : RTI;
                SEL_IR:  tap_d = tms_s ? TLR    : CAP_IR;
                CAP_IR:  tap_d = tms_s ? EX1_IR : SH_IR;
                SH_IR:   tap_d = tms_s ? EX1_IR : SH_IR;
                EX1_IR:  tap_d = tms_s ? UPD_IR : PAU_IR;
                PAU_IR:  tap_d = tms_s ? EX2_IR : PAU_IR;
                EX2_IR:  tap_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR:  tap_d = tms_s ? SEL_DR : RTI;
                default: tap_d = TLR;
            endcase
        if (!trst_s) tap_d = TLR;
    end

    always_comb begin
        ir_sr_d = ir_sr_q;
        ir_d    = ir_q;
        dr_d    = dr_q;
        tdo_d   = tdo_q;
        dmi_d   = dmi_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        stat_d  = stat_q;
        if (cap_ir) ir_sr_d = 5'b00001;
        else if (sh_ir) ir_sr_d = {tdi_s, ir_sr_q[4:1]};
        if (tap_q == TLR) ir_d = 5'h01;
        else if (upd_ir) ir_d = ir_sr_q;
        if (cap_dr) dr_d = sel_dmi ? {addr_q, rdata_q, cap_st} : sel_cs ? DW'(dtmcs) : sel_id ? DW'(IDCODE_VALUE) : '0;
        else if (sh_dr) dr_d = sel_dmi ? {tdi_s, dr_q[DW-1:1]} : sel_byp ? DW'(tdi_s) : DW'({tdi_s, dr_q[31:1]});
        if (fall) tdo_d = tap_q == SH_IR ? ir_sr_q[0] : dr_q[0];
        if (dmi_q == D_REQ && dmi.dmi_req_ready) dmi_d = D_RESP;
        if (dmi_q == D_RESP && dmi.dmi_resp_valid && !hard) begin
            dmi_d   = D_IDLE;
            rdata_d = dmi.dmi_resp_data;
            resp_d  = dmi.dmi_resp_resp == 2'd2 ? 2'd2 : 2'd0;
            if (dmi.dmi_resp_resp == 2'd2 && stat_q == 2'd0) stat_d = 2'd2;
        end
        // A scan that touches DMIACCESS while busy poisons dmistat until dmireset
        if (sel_dmi && dmi_q != D_IDLE && (cap_dr || upd_dr)) stat_d = 2'd3;
        if (upd_dr && sel_dmi && dmi_q == D_IDLE && stat_q == 2'd0 && (dr_q[1:0] == 2'd1 || dr_q[1:0] == 2'd2)) begin
            dmi_d   = D_REQ;
            addr_d  = dr_q[DW-1:34];
            wdata_d = dr_q[33:2];
            op_d    = dr_q[1:0];
        end
        if (upd_dr && sel_cs && (dr_q[16] || dr_q[17])) stat_d = 2'd0;
        if (hard) dmi_d = D_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q    <= '0;
            s1_q    <= '0;
            tck_p_q <= 1'b0;
            tap_q   <= TLR;
            dmi_q   <= D_IDLE;
            ir_sr_q <= '0;
            ir_q    <= 5'h01;
            dr_q    <= '0;
            tdo_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
            stat_q  <= '0;
        end else begin
            s0_q    <= {trst_n, tck, tms, tdi};
            s1_q    <= s0_q;
            tck_p_q <= tck_s;
            tap_q   <= tap_d;
            dmi_q   <= dmi_d;
            ir_sr_q <= ir_sr_d;
            ir_q    <= ir_d;
            dr_q    <= dr_d;
            tdo_q   <= tdo_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            stat_q  <= stat_d;
        end
    end

    assign tdo                = tdo_q;
    assign tdo_oe             = tap_q == SH_IR || tap_q == SH_DR;
    assign dmi.dmi_req_valid  = dmi_q == D_REQ;
    assign dmi.dmi_resp_ready = dmi_q == D_RESP;
    assign dmi.dmi_req_addr   = addr_q;
    assign dmi.dmi_req_data   = wdata_q;
    assign dmi.dmi_req_op     = op_q;
endmodule

// File: tb/tb_jtag_dtm_oversampled.sv
// tb_jtag_dtm_oversampled: drives JTAG scans and a randomized DM responder against a transaction-level model.
module tb_jtag_dtm_oversampled;
    localparam int H = 6;
    logic clk = 0, rst = 1, tck = 0, tms = 1, tdi = 0, trst_n = 1;
    logic tdo, tdo_oe;
    int n_cmp = 0, n_err = 0;

    jtag_dtm_oversampled_if #(.ABITS(7)) dmi ();
    jtag_dtm_oversampled #(.IDCODE_VALUE(32'h0000_0001), .ABITS(7), .IDLE_HINT(3'd1)) dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .trst_n(trst_n),
        .tdo(tdo), .tdo_oe(tdo_oe), .dmi(dmi)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Debug-module stand-in: memory-backed, with adjustable stall, latency and failure
    logic [31:0] dm_mem [128];
    logic [31:0] ref_mem[128];
    bit          dm_stall = 0, dm_fail = 0;
    int          dm_lat = 3;
    logic [6:0]  dm_a;
    logic [1:0]  dm_op;
    logic [31:0] dm_d;

    initial begin
        dmi.dmi_req_ready  = 0;
        dmi.dmi_resp_valid = 0;
        dmi.dmi_resp_data  = 0;
        dmi.dmi_resp_resp  = 0;
        forever begin
            @(negedge clk);
            if (dmi.dmi_req_valid && !dm_stall) begin
                dm_a = dmi.dmi_req_addr;
                dm_op = dmi.dmi_req_op;
                dm_d = dmi.dmi_req_data;
                dmi.dmi_req_ready = 1;
                @(negedge clk);
                dmi.dmi_req_ready = 0;
                if (dm_op == 2) dm_mem[dm_a] = dm_d;
                repeat (dm_lat) @(negedge clk);
                dmi.dmi_resp_valid = 1;
                dmi.dmi_resp_data  = dm_op == 1 ? dm_mem[dm_a] : 32'h0;
                dmi.dmi_resp_resp  = dm_fail ? 2'd2 : 2'd0;
                for (int k = 0; k < 200 && !dmi.dmi_resp_ready; k++) @(negedge clk);
                @(negedge clk);
                dmi.dmi_resp_valid = 0;
            end
        end
    end

    // Transaction-level model of the DTM's visible state
    logic [1:0]  m_stat = 0, m_resp = 0, p_op;
    logic [31:0] m_rdata = 0, p_data;
    logic [6:0]  m_addr = 0, p_addr;
    bit          m_busy = 0;

    task automatic m_complete();
        m_busy = 0;
        if (p_op == 2) ref_mem[p_addr] = p_data;
        m_rdata = p_op == 1 ? ref_mem[p_addr] : 32'h0;
        if (dm_fail) begin
            m_resp = 2;
            if (m_stat == 0) m_stat = 2;
        end else m_resp = 0;
    endtask

    task automatic m_dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op, output logic [40:0] e);
        e = {m_addr, m_rdata, (m_busy || m_stat == 2'd3) ? 2'd3 : m_resp};
        if (m_busy) m_stat = 3;
        else if (m_stat == 0 && (op == 1 || op == 2)) begin
            m_addr = a; p_addr = a; p_data = d; p_op = op; m_busy = 1;
            if (!dm_stall) m_complete();
        end
    endtask

    task automatic m_dtmcs(input logic [31:0] wr, output logic [40:0] e);
        e = {9'b0, 17'b0, 3'd1, m_stat, 6'd7, 4'd1};
        if (wr[17]) begin m_stat = 0; m_busy = 0; end
        else if (wr[16]) m_stat = 0;
    endtask

    task automatic tclk(input bit m, input bit d, output bit o, output bit oe);
        tck = 0; tms = m; tdi = d;
        repeat (H) @(negedge clk);
        o = tdo; oe = tdo_oe;
        tck = 1;
        repeat (H) @(negedge clk);
    endtask

    task automatic step(input bit m);
        bit o, e;
        tclk(m, 0, o, e);
    endtask

    task automatic ir_scan(input logic [4:0] v, output logic [4:0] cap);
        bit o, e, oe_all;
        oe_all = 1;
        step(1); step(1); step(0); step(0);
        for (int i = 0; i < 5; i++) begin
            tclk(i == 4, v[i], o, e);
            cap[i] = o; oe_all &= e;
        end
        step(1); step(0);
        check("ir_oe", {63'b0, oe_all}, 64'd1);
    endtask

    task automatic dr_scan(input int len, input logic [40:0] v, output logic [40:0] cap);
        bit o, e, oe_all;
        oe_all = 1; cap = '0;
        step(1); step(0); step(0);
        for (int i = 0; i < len; i++) begin
            tclk(i == len - 1, v[i], o, e);
            cap[i] = o; oe_all &= e;
        end
        step(1); step(0);
        check("dr_oe", {63'b0, oe_all}, 64'd1);
        check("idle_oe", {63'b0, tdo_oe}, 64'd0);
    endtask

    task automatic do_dmi(input string tag, input logic [6:0] a, input logic [31:0] d, input logic [1:0] op, output logic [40:0] c);
        logic [4:0] ic;
        logic [40:0] e;
        ir_scan(5'h11, ic);
        check({tag, "_ircap"}, 64'(ic), 64'h01);
        m_dmi(a, d, op, e);
        dr_scan(41, {a, d, op}, c);
        check(tag, 64'(c), 64'(e));
        repeat (30) @(negedge clk);
    endtask

    task automatic do_dtmcs(input string tag, input logic [31:0] wr, output logic [40:0] c);
        logic [4:0] ic;
        logic [40:0] e;
        ir_scan(5'h10, ic);
        m_dtmcs(wr, e);
        dr_scan(32, 41'(wr), c);
        check(tag, 64'(c), 64'(e));
        repeat (30) @(negedge clk);
    endtask

    initial begin
        logic [40:0] c;
        logic [6:0]  a;
        logic [31:0] d;
        for (int i = 0; i < 128; i++) begin
            dm_mem[i] = $urandom;
            ref_mem[i] = dm_mem[i];
        end
        dm_mem[7'h11] = 32'h00400c82;
        ref_mem[7'h11] = 32'h00400c82;
        repeat (4) @(negedge clk);
        check("rst_tdo", {63'b0, tdo}, 0);
        check("rst_oe", {63'b0, tdo_oe}, 0);
        check("rst_req_valid", {63'b0, dmi.dmi_req_valid}, 0);
        check("rst_resp_ready", {63'b0, dmi.dmi_resp_ready}, 0);
        rst = 0;
        repeat (4) @(negedge clk);
        repeat (5) step(1);
        step(0);
        dr_scan(32, 41'h0, c);
        check("idcode", 64'(c), 64'h1);

        do_dtmcs("dtmcs0", 32'h0, c);
        check("dtmcs0_const", 64'(c), 64'h1071);

        dm_lat = 5;
        do_dmi("rd_issue", 7'h11, 32'h0, 2'd1, c);
        do_dmi("rd_result", 7'h11, 32'h0, 2'd0, c);
        check("rd_const", 64'(c), 64'({7'h11, 32'h00400c82, 2'b00}));

        dm_stall = 1;
        d = $urandom;
        do_dmi("stall_wr", 7'h22, d, 2'd2, c);
        do_dmi("stall_cap", 7'h22, 32'h0, 2'd0, c);
        check("stall_op3", 64'(c[1:0]), 64'd3);
        do_dtmcs("dtmcs_busy", 32'h0, c);
        check("dmistat3", 64'(c[11:10]), 64'd3);
        do_dtmcs("dmireset", 32'h0001_0000, c);
        dm_stall = 0;
        repeat (40) @(negedge clk);
        m_complete();
        do_dtmcs("dtmcs_clr", 32'h0, c);
        check("dmistat0", 64'(c[11:10]), 64'd0);
        do_dmi("stall_done", 7'h00, 32'h0, 2'd0, c);
        check("stall_mem", 64'(dm_mem[7'h22]), 64'(d));

        dm_fail = 1;
        do_dmi("fail_rd", 7'h05, 32'h0, 2'd1, c);
        dm_fail = 0;
        do_dmi("fail_cap", 7'h06, 32'h0, 2'd1, c);
        check("fail_op2", 64'(c[1:0]), 64'd2);
        do_dmi("fail_supp", 7'h07, 32'h0, 2'd0, c);
        check("fail_addr", 64'(c[40:34]), 64'h05);
        do_dtmcs("fail_stat", 32'h0001_0000, c);

        dm_stall = 1;
        do_dmi("hr_req", 7'h09, 32'h0, 2'd1, c);
        do_dtmcs("hardreset", 32'h0002_0000, c);
        dm_stall = 0;
        repeat (40) @(negedge clk);
        check("hr_valid", {63'b0, dmi.dmi_req_valid}, 0);
        do_dmi("hr_cap", 7'h00, 32'h0, 2'd0, c);

        dm_stall = 1;
        a = 7'h33; d = $urandom;
        do_dmi("trst_req", a, d, 2'd2, c);
        trst_n = 0;
        step(0); step(0);
        trst_n = 1;
        dm_stall = 0;
        repeat (40) @(negedge clk);
        m_complete();
        step(0);
        dr_scan(32, 41'h0, c);
        check("trst_idcode", 64'(c), 64'h1);
        do_dmi("trst_done", 7'h00, 32'h0, 2'd0, c);
        check("trst_mem", 64'(dm_mem[a]), 64'(d));

        for (int i = 0; i < 14; i++) begin
            dm_fail = $urandom_range(0, 3) == 0;
            dm_lat = $urandom_range(0, 6);
            do_dmi("rnd", 7'($urandom_range(0, 7)), $urandom, 2'($urandom_range(0, 3)), c);
            if (m_stat != 0 && $urandom_range(0, 1) == 1) do_dtmcs("rnd_clr", 32'h0001_0000, c);
        end
        dm_fail = 0;

        dm_stall = 1;
        do_dmi("rst_req", 7'h12, 32'h0, 2'd1, c);
        check("rst_pre_valid", {63'b0, dmi.dmi_req_valid}, 1);
        rst = 1;
        #1;
        check("rst_async_valid", {63'b0, dmi.dmi_req_valid}, 0);
        check("rst_async_tdo", {63'b0, tdo}, 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
